// File: rtl/sort4_ctrl_pkg.sv
// Shared definitions for the sort4_ctrl sorting sequencer.
//   ELEM_W  : element width, fixed by the 2-bit comparator
//   SWAPS_W : width of the saturating swap counter
//   state_t : controller states (LOAD / SORT / DRAIN)
package sort4_ctrl_pkg;

    localparam int unsigned ELEM_W  = 2;
    localparam int unsigned SWAPS_W = 8;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sort4_ctrl_cmp.sv
// Existing 2-bit combinational magnitude comparator.
//   x, y : operands
//   eq   : x == y
//   le   : x <= y
//   gt   : x >  y
module sort4_ctrl_cmp
    import sort4_ctrl_pkg::*;
(
    input  logic [ELEM_W-1:0] x,
    input  logic [ELEM_W-1:0] y,
    output logic              eq,
    output logic              le,
    output logic              gt
);

    assign eq = (x == y);
    assign le = (x <= y);
    assign gt = (x >  y);

endmodule

// File: rtl/sort4_ctrl.sv
// Sequential bubble-sort controller time-sharing one comparator.
// Loads N elements over a valid/ready stream, sorts them in place with one
// compare per cycle (early exit on a swap-free pass), then streams them out
// in ascending order.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake, in_data element to load
//   out_valid/out_ready : output handshake, out_data sorted element
//   busy                : high while sorting or draining
//   swaps               : saturating swap count of the last/current batch
module sort4_ctrl
    import sort4_ctrl_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ELEM_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ELEM_W-1:0]  out_data,
    output logic               busy,
    output logic [SWAPS_W-1:0] swaps
);

    localparam int unsigned CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_CMP = CNT_W'(N - 2);
    localparam logic [SWAPS_W-1:0] SWAPS_MAX = {SWAPS_W{1'b1}};

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   ld_idx, ld_idx_nxt;
    logic [CNT_W-1:0]   out_idx, out_idx_nxt;
    logic [CNT_W-1:0]   i, i_nxt;
    logic [CNT_W-1:0]   pass, pass_nxt;
    logic               swapped, swapped_nxt;
    logic [SWAPS_W-1:0] swaps_nxt;
    logic [ELEM_W-1:0]  regs     [N];
    logic [ELEM_W-1:0]  regs_nxt [N];

    logic               in_ready_nxt;
    logic               out_valid_nxt;
    logic               busy_nxt;
    logic [ELEM_W-1:0]  out_data_nxt;

    logic [CNT_W-1:0]   i_plus1;
    logic               cmp_gt;
    logic               cmp_eq_unused;
    logic               cmp_le_unused;
    logic               swap_any;

    assign i_plus1 = i + CNT_W'(1);

    // Single shared comparator: always looks at the adjacent pair under i.
    sort4_ctrl_cmp u_cmp (
        .x  (regs[i]),
        .y  (regs[i_plus1]),
        .eq (cmp_eq_unused),
        .le (cmp_le_unused),
        .gt (cmp_gt)
    );

    // State, counters, register file and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_LOAD;
            ld_idx    <= '0;
            out_idx   <= '0;
            i         <= '0;
            pass      <= '0;
            swapped   <= 1'b0;
            swaps     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            for (int k = 0; k < int'(N); k++) begin
                regs[k] <= '0;
            end
        end else begin
            state     <= state_nxt;
            ld_idx    <= ld_idx_nxt;
            out_idx   <= out_idx_nxt;
            i         <= i_nxt;
            pass      <= pass_nxt;
            swapped   <= swapped_nxt;
            swaps     <= swaps_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
            out_data  <= out_data_nxt;
            for (int k = 0; k < int'(N); k++) begin
                regs[k] <= regs_nxt[k];
            end
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_nxt   = state;
        ld_idx_nxt  = ld_idx;
        out_idx_nxt = out_idx;
        i_nxt       = i;
        pass_nxt    = pass;
        swapped_nxt = swapped;
        swaps_nxt   = swaps;
        swap_any    = swapped;
        for (int k = 0; k < int'(N); k++) begin
            regs_nxt[k] = regs[k];
        end

        unique case (state)
            ST_LOAD: begin
                // in_ready is high exactly in LOAD, so it gates acceptance.
                if (in_valid && in_ready) begin
                    regs_nxt[ld_idx] = in_data;
                    if (ld_idx == LAST_IDX) begin
                        ld_idx_nxt  = '0;
                        pass_nxt    = '0;
                        i_nxt       = '0;
                        swapped_nxt = 1'b0;
                        swaps_nxt   = '0;
                        state_nxt   = ST_SORT;
                    end else begin
                        ld_idx_nxt = ld_idx + CNT_W'(1);
                    end
                end
            end

            ST_SORT: begin
                // Strict gt only: equal elements keep their order.
                if (cmp_gt) begin
                    regs_nxt[i]       = regs[i_plus1];
                    regs_nxt[i_plus1] = regs[i];
                    if (swaps != SWAPS_MAX) begin
                        swaps_nxt = swaps + SWAPS_W'(1);
                    end
                end
                swap_any = swapped | cmp_gt;

                if (i == LAST_CMP) begin
                    i_nxt       = '0;
                    swapped_nxt = 1'b0;
                    if (!swap_any || (pass == LAST_CMP)) begin
                        pass_nxt    = '0;
                        out_idx_nxt = '0;
                        state_nxt   = ST_DRAIN;
                    end else begin
                        pass_nxt = pass + CNT_W'(1);
                    end
                end else begin
                    i_nxt       = i_plus1;
                    swapped_nxt = swap_any;
                end
            end

            ST_DRAIN: begin
                if (out_valid && out_ready) begin
                    if (out_idx == LAST_IDX) begin
                        out_idx_nxt = '0;
                        state_nxt   = ST_LOAD;
                    end else begin
                        out_idx_nxt = out_idx + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = ST_LOAD;
            end
        endcase

        // Outputs are decoded from next state so they register in step with it.
        in_ready_nxt  = (state_nxt == ST_LOAD);
        out_valid_nxt = (state_nxt == ST_DRAIN);
        busy_nxt      = (state_nxt == ST_SORT) || (state_nxt == ST_DRAIN);
        out_data_nxt  = (state_nxt == ST_DRAIN) ? regs_nxt[out_idx_nxt] : '0;
    end

endmodule

// File: tb/tb_sort4_ctrl.sv
// Self-checking bench for sort4_ctrl: directed and random batches compared
// against an inversion-count / counting-sort reference model.
module tb_sort4_ctrl;

    localparam int NE = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_data;
    logic       busy;
    logic [7:0] swaps;

    int total = 0;
    int bad   = 0;

    logic [1:0] batch      [NE];
    logic [1:0] exp_sorted [NE];
    int         exp_swaps;
    int         exp_cycles;

    sort4_ctrl #(.N(NE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .swaps     (swaps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: swaps = inversions; passes = 1 + max left-larger count, capped.
    function automatic void model();
        int cnt [4];
        int inv;
        int lmax;
        int p;
        int idx;
        inv  = 0;
        lmax = 0;
        for (int j = 0; j < NE; j++) begin
            int l;
            l = 0;
            for (int k = 0; k < j; k++) begin
                if (batch[k] > batch[j]) l++;
            end
            inv += l;
            if (l > lmax) lmax = l;
        end
        p = (lmax + 1 < NE - 1) ? lmax + 1 : NE - 1;
        exp_swaps  = inv;
        exp_cycles = p * (NE - 1);
        for (int v = 0; v < 4; v++) cnt[v] = 0;
        for (int k = 0; k < NE; k++) cnt[batch[k]]++;
        idx = 0;
        for (int v = 0; v < 4; v++) begin
            for (int c = 0; c < cnt[v]; c++) begin
                exp_sorted[idx] = 2'(v);
                idx++;
            end
        end
    endfunction

    task automatic set_batch(input logic [1:0] a, input logic [1:0] b,
                             input logic [1:0] c, input logic [1:0] d);
        batch[0] = a; batch[1] = b; batch[2] = c; batch[3] = d;
    endtask

    // Called at a negedge; returns at the negedge after the last accepting edge.
    task automatic load_batch(input bit gaps);
        for (int k = 0; k < NE; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 2'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = batch[k];
            chk("in_ready_load", 32'(in_ready), 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_batch(input bit gaps, input int bp_idx, input bit poke);
        int cyc;
        model();
        load_batch(gaps);
        chk("sort_start_busy", 32'(busy), 1);
        chk("sort_start_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        cyc = 0;
        while (busy === 1'b1 && out_valid !== 1'b1 && cyc < 200) begin
            if (poke) begin
                in_valid = 1'b1;
                in_data  = 2'($urandom);
                chk("in_ready_sort", 32'(in_ready), 0);
            end
            cyc++;
            @(negedge clk);
        end
        chk("sort_cycles", 32'(cyc), 32'(exp_cycles));
        chk("swaps", 32'(swaps), 32'(exp_swaps));
        for (int k = 0; k < NE; k++) begin
            if (k == bp_idx) begin
                out_ready = 1'b0;
                repeat (3) begin
                    chk("hold_valid", 32'(out_valid), 1);
                    chk("hold_data", 32'(out_data), 32'(exp_sorted[k]));
                    if (poke) chk("in_ready_drain", 32'(in_ready), 0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            chk("out_valid", 32'(out_valid), 1);
            chk("out_data", 32'(out_data), 32'(exp_sorted[k]));
            chk("drain_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("post_in_ready", 32'(in_ready), 1);
        chk("post_out_valid", 32'(out_valid), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_swaps", 32'(swaps), 32'(exp_swaps));
    endtask

    task automatic check_reset_state();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_swaps", 32'(swaps), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 2'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;

        // Reset while sorting abandons the batch.
        set_batch(2'd3, 2'd1, 2'd2, 2'd0);
        load_batch(1'b0);
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        set_batch(2'd2, 2'd0, 2'd3, 2'd1);
        run_batch(1'b0, -1, 1'b0);

        // Reverse-ish, presorted, duplicates.
        set_batch(2'd3, 2'd1, 2'd2, 2'd0);
        run_batch(1'b0, -1, 1'b0);
        chk("rev_swaps_const", 32'(swaps), 5);
        set_batch(2'd0, 2'd1, 2'd2, 2'd3);
        run_batch(1'b0, -1, 1'b0);
        set_batch(2'd2, 2'd2, 2'd1, 2'd2);
        run_batch(1'b0, -1, 1'b0);
        chk("dup_swaps_const", 32'(swaps), 2);

        // Backpressure on element 1 plus ignored in_valid during SORT/DRAIN.
        set_batch(2'd3, 2'd1, 2'd2, 2'd0);
        run_batch(1'b0, 1, 1'b1);

        // Input gaps.
        set_batch(2'd3, 2'd1, 2'd2, 2'd0);
        run_batch(1'b1, -1, 1'b0);

        // Random batches.
        for (int r = 0; r < 20; r++) begin
            set_batch(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
            run_batch(1'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NE - 1)) : -1,
                      1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
